// File: rtl/pfifo_writer.sv
// pfifo_writer: packet ingress stage in front of the packet FIFO.
// Accepts a byte stream with end-of-packet marking and drives the FIFO's
// put / commit / drop strobes. Only complete, in-length, non-overflowed
// packets are committed; everything else is rolled back with drop.
// Optional feature macro: PFIFO_WRITER_CHECKSUM_EN (last word is a checksum;
// the W-bit sum of all packet words must be zero for the packet to commit).
module pfifo_writer #(
   parameter int W       = 8,
   parameter int MAX_LEN = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] in,
   input  logic         valid,
   input  logic         last,
   input  logic         abort,
   output logic         ready,
   output logic [W-1:0] out,
   output logic         put,
   input  logic         full,
   output logic         commit,
   output logic         drop,
   output logic [15:0]  ok_count,
   output logic [15:0]  drop_count
);

   typedef enum logic [2:0] {IDLE, BODY, PUT, SKIP, COMMIT, DROP} state_t;

   localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

   state_t      state;
   state_t      state_nx;
   logic [15:0] len;      // words written for the current packet
   logic        last_q;   // last flag of the word being put
   logic        sum_ok;   // packet checksum verdict, valid in PUT

`ifdef PFIFO_WRITER_CHECKSUM_EN
   logic [W-1:0] sum;

   assign sum_ok = (sum == '0);

   // Running W-bit sum of written words, cleared when the packet resolves.
   always_ff @(posedge clock) begin
      if (reset) begin
         sum <= '0;
      end else if (state_nx == PUT) begin
         sum <= sum + in;
      end else if (state == COMMIT || state == DROP) begin
         sum <= '0;
      end
   end
`else
   assign sum_ok = 1'b1;
`endif

   // Words are taken only in the states that can consume them.
   assign ready = (state == IDLE) || (state == BODY) || (state == SKIP);

   // Next-state decision; every accepted word is resolved here.
   always_comb begin
      // NOTE: default assigned first so no path leaves state_nx unassigned,
      // which would otherwise infer a latch.
      state_nx = state;
      case (state)
         IDLE, BODY: begin
            if (valid) begin
               if (abort) begin
                  state_nx = DROP;
               end else if (full || len == MAX_LEN_C) begin
                  // Overflowed word that also ends the packet has nothing
                  // left to skip, so it resolves straight to DROP.
                  state_nx = last ? DROP : SKIP;
               end else begin
                  state_nx = PUT;
               end
            end
         end
         PUT: begin
            if (!last_q)     state_nx = BODY;
            else if (sum_ok) state_nx = COMMIT;
            else             state_nx = DROP;
         end
         SKIP: begin
            if (valid && (last || abort)) state_nx = DROP;
         end
         COMMIT, DROP: state_nx = IDLE;
         default:      state_nx = IDLE;
      endcase
   end

   // State register, registered strobes, data path and counters.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments in clocked logic so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state      <= IDLE;
         out        <= '0;
         put        <= 1'b0;
         commit     <= 1'b0;
         drop       <= 1'b0;
         ok_count   <= '0;
         drop_count <= '0;
         len        <= '0;
         last_q     <= 1'b0;
      end else begin
         state  <= state_nx;
         put    <= (state_nx == PUT);
         commit <= (state_nx == COMMIT);
         drop   <= (state_nx == DROP);
         // Entering PUT only happens on a written word.
         if (state_nx == PUT) begin
            out    <= in;
            len    <= len + 16'd1;
            last_q <= last;
         end
         if (state == COMMIT) begin
            ok_count <= ok_count + 16'd1;
            len      <= '0;
         end
         if (state == DROP) begin
            drop_count <= drop_count + 16'd1;
            len        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pfifo_writer.sv
// tb_pfifo_writer: directed bench for pfifo_writer (MAX_LEN = 4).
// A packet-level model predicts, per cycle, the put/commit/drop pulses,
// the word on out, ready and both counters; a compare process checks them
// every cycle. Literal expectations pin pulse timing and counter totals.
module tb_pfifo_writer;

   localparam int W       = 8;
   localparam int MAX_LEN = 4;
`ifdef PFIFO_WRITER_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] din   = '0;
   logic         valid = 1'b0;
   logic         last  = 1'b0;
   logic         abort = 1'b0;
   logic         full  = 1'b0;
   logic         ready;
   logic [W-1:0] dout;
   logic         put;
   logic         commit;
   logic         drop;
   logic [15:0]  ok_count;
   logic [15:0]  drop_count;

   pfifo_writer #(.W(W), .MAX_LEN(MAX_LEN)) dut (
      .clock(clock), .reset(reset), .in(din), .valid(valid), .last(last),
      .abort(abort), .ready(ready), .out(dout), .put(put), .full(full),
      .commit(commit), .drop(drop), .ok_count(ok_count),
      .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   int   cyc      = 0;
   logic rst_seen = 1'b1;
   int   n_cmp    = 0;
   int   n_bad    = 0;

   always @(posedge clock) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- packet-level model ----------------
   logic [W-1:0] exp_put[int];   // cycle -> word that must be on out with put
   bit           exp_com[int];
   bit           exp_drp[int];
   int           m_len  = 0;
   bit           m_skip = 1'b0;
   logic [W-1:0] m_sum  = '0;

   function automatic void pkt_clear();
      m_len  = 0;
      m_skip = 1'b0;
      m_sum  = '0;
   endfunction

   // Word accepted in cycle c: decide its fate and the packet's outcome.
   function automatic void model_accept(int c, logic [W-1:0] w, bit l, bit a, bit f);
      if (m_skip) begin
         if (l || a) begin
            exp_drp[c+1] = 1'b1;
            pkt_clear();
         end
      end else if (a) begin
         exp_drp[c+1] = 1'b1;
         pkt_clear();
      end else if (f || m_len == MAX_LEN) begin
         if (l) begin
            exp_drp[c+1] = 1'b1;
            pkt_clear();
         end else begin
            m_skip = 1'b1;
         end
      end else begin
         exp_put[c+1] = w;
         m_len++;
         m_sum += w;
         if (l) begin
            if (CHK && m_sum != 0) exp_drp[c+2] = 1'b1;
            else                   exp_com[c+2] = 1'b1;
            pkt_clear();
         end
      end
   endfunction

   // Reset raised during cycle k cancels everything predicted after k.
   function automatic void model_reset(int k);
      for (int i = k + 1; i <= k + 3; i++) begin
         exp_put.delete(i);
         exp_com.delete(i);
         exp_drp.delete(i);
      end
      pkt_clear();
   endfunction

   // ---------------- per-cycle compare ----------------
   logic [W-1:0] exp_out = '0;
   int           exp_ok  = 0;
   int           exp_dr  = 0;
   int           put_log[$];
   int           last_commit = -1;
   int           last_drop   = -1;

   always @(negedge clock) begin
      bit e_put, e_com, e_drp;
      if (cyc > 0) begin
         if (rst_seen) begin
            exp_out = '0;
            exp_ok  = 0;
            exp_dr  = 0;
         end
         e_put = exp_put.exists(cyc);
         e_com = exp_com.exists(cyc);
         e_drp = exp_drp.exists(cyc);
         if (e_put) exp_out = exp_put[cyc];
         check("put",        32'(put),        32'(e_put));
         check("commit",     32'(commit),     32'(e_com));
         check("drop",       32'(drop),       32'(e_drp));
         check("ready",      32'(ready),      32'(!(e_put || e_com || e_drp)));
         check("out",        32'(dout),       32'(exp_out));
         check("ok_count",   32'(ok_count),   32'(exp_ok[15:0]));
         check("drop_count", 32'(drop_count), 32'(exp_dr[15:0]));
         if (e_com) exp_ok++;
         if (e_drp) exp_dr++;
         if (put === 1'b1)    put_log.push_back(cyc);
         if (commit === 1'b1) last_commit = cyc;
         if (drop === 1'b1)   last_drop = cyc;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send(logic [W-1:0] w, bit l, bit a, bit f);
      bit acc = 1'b0;
      din   = w;
      valid = 1'b1;
      last  = l;
      abort = a;
      full  = f;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clock);
         if (ready === 1'b1) begin
            model_accept(cyc, w, l, a, f);
            acc = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      valid = 1'b0;
      last  = 1'b0;
      abort = 1'b0;
      full  = 1'b0;
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_counts(string tag, int ok, int dr);
      @(negedge clock);
      check({tag, "_ok"}, 32'(ok_count),   32'(ok));
      check({tag, "_dr"}, 32'(drop_count), 32'(dr));
   endtask

   initial begin
      int s;
      int d0;
      int ok_x[6];
      int dr_x[6];
      if (CHK) begin
         ok_x = '{0, 1, 1, 1, 1, 1};
         dr_x = '{1, 1, 2, 3, 4, 5};
      end else begin
         ok_x = '{1, 2, 3, 3, 3, 3};
         dr_x = '{0, 0, 0, 1, 2, 3};
      end

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      idle(2);
      @(negedge clock);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_out",   32'(dout),  32'd0);
      idle(1);

      // 3-word packet: puts at s+1, s+3, s+5, resolution at s+6.
      s = cyc;
      put_log.delete();
      send(8'h11, 0, 0, 0);
      send(8'h22, 0, 0, 0);
      send(8'h33, 1, 0, 0);
      idle(3);
      check("a_nput", 32'(put_log.size()), 32'd3);
      if (put_log.size() == 3) begin
         check("a_put0", 32'(put_log[0]), 32'(s + 1));
         check("a_put1", 32'(put_log[1]), 32'(s + 3));
         check("a_put2", 32'(put_log[2]), 32'(s + 5));
      end
      if (!CHK) check("a_commit_cyc", 32'(last_commit), 32'(s + 6));
      expect_counts("a", ok_x[0], dr_x[0]);
      idle(1);

      // Checksum packets: sum 0x100 -> good; sum 0x101 -> bad when enabled.
      send(8'h10, 0, 0, 0);
      send(8'h20, 0, 0, 0);
      send(8'hD0, 1, 0, 0);
      idle(3);
      expect_counts("c1", ok_x[1], dr_x[1]);
      idle(1);
      put_log.delete();
      send(8'h10, 0, 0, 0);
      send(8'h20, 0, 0, 0);
      send(8'hD1, 1, 0, 0);
      idle(3);
      check("c2_nput", 32'(put_log.size()), 32'd3);
      expect_counts("c2", ok_x[2], dr_x[2]);
      idle(1);

      // full on word 2 of 4: one put, words 3/4 swallowed, drop at s+5.
      s = cyc;
      put_log.delete();
      send(8'h41, 0, 0, 0);
      send(8'h42, 0, 0, 1);
      send(8'h43, 0, 0, 0);
      send(8'h44, 1, 0, 0);
      idle(3);
      check("f_nput",    32'(put_log.size()), 32'd1);
      check("f_drop_cyc", 32'(last_drop),     32'(s + 5));
      expect_counts("f", ok_x[3], dr_x[3]);
      idle(1);

      // 6 words against MAX_LEN=4: four puts, drop at s+10.
      s = cyc;
      put_log.delete();
      for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), (i == 5), 0, 0);
      idle(3);
      check("m_nput",     32'(put_log.size()), 32'd4);
      check("m_drop_cyc", 32'(last_drop),      32'(s + 10));
      expect_counts("m", ok_x[4], dr_x[4]);
      idle(1);

      // abort on word 2: drop at s+3, ready back at s+4.
      s = cyc;
      put_log.delete();
      send(8'h61, 0, 0, 0);
      send(8'h62, 0, 1, 0);
      check("ab_drop_now", 32'(cyc), 32'(s + 3));
      @(posedge clock);
      @(negedge clock);
      check("ab_ready", 32'(ready), 32'd1);
      check("ab_nput",  32'(put_log.size()), 32'd1);
      check("ab_drop_cyc", 32'(last_drop), 32'(s + 3));
      expect_counts("ab", ok_x[5], dr_x[5]);
      idle(1);

      // abort without valid is ignored.
      d0 = last_drop;
      abort = 1'b1;
      idle(3);
      abort = 1'b0;
      idle(2);
      check("abort_novalid", 32'(last_drop), 32'(d0));

      // reset while in PUT: no drop, everything cleared, next packet commits.
      send(8'h55, 0, 0, 0);
      @(negedge clock);
      check("rp_in_put", 32'(put), 32'd1);
      #1;
      reset = 1'b1;
      model_reset(cyc);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rp_put",    32'(put),    32'd0);
      check("rp_drop",   32'(drop),   32'd0);
      check("rp_commit", 32'(commit), 32'd0);
      check("rp_out",    32'(dout),   32'd0);
      check("rp_ready",  32'(ready),  32'd1);
      check("rp_ok",     32'(ok_count),   32'd0);
      check("rp_dr",     32'(drop_count), 32'd0);
      d0 = last_drop;
      idle(1);
      send(8'h01, 0, 0, 0);
      send(8'hFF, 1, 0, 0);
      idle(3);
      check("rp_nodrop", 32'(last_drop), 32'(d0));
      expect_counts("rp", 1, 0);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
